// File: rtl/dds_pkg.sv
// dds_pkg: shared DDS types and default widths for the sweep controller and waveform stages.
package dds_pkg;
    localparam int DDS_N = 14;
    localparam int DDS_D = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SWEEP = ST_SWEEP,
        HOLD  = ST_HOLD
    } sweep_state_t;
endpackage

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: N-bit registered phase accumulator with registered carry-out as wrap pulse.
module dds_phase_acc import dds_pkg::*; #(
    parameter int N = DDS_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] ftw_i,
    output logic [N-1:0] phase_o,
    output logic         wrap_o
);
    logic [N-1:0] phase_q;
    logic         wrap_q;
    logic [N:0]   sum;
    assign sum = {1'b0, phase_q} + {1'b0, ftw_i};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            phase_q <= sum[N-1:0];
            wrap_q  <= sum[N];
        end
    end
    assign phase_o = phase_q;
    assign wrap_o  = wrap_q;
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: FTW start-to-stop sweep sequencer with dwell, clamp and phase accumulator.
// Define DDS_SWEEP_PINGPONG_EN for an endless triangular sweep between start and stop.
module dds_sweep_ctrl import dds_pkg::*; #(
    parameter int N = DDS_N,
    parameter int D = DDS_D
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid_i,
    output logic         cfg_ready_o,
    input  logic [N-1:0] cfg_start_i,
    input  logic [N-1:0] cfg_stop_i,
    input  logic [N-1:0] cfg_step_i,
    input  logic [D-1:0] cfg_dwell_i,
    input  logic         start_i,
    input  logic         abort_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] ftw_o,
    output logic [N-1:0] phase_o,
    output logic         wrap_o
);
    sweep_state_t state_q, state_d;
    logic [N-1:0] start_sh_q, stop_sh_q, step_sh_q;
    logic [D-1:0] dwell_sh_q;
    logic         up_sh_q;
    logic [N-1:0] ftw_q, ftw_d;
    logic [D-1:0] cnt_q, cnt_d;
    logic         done_q, done_d;
    logic         cfg_acc;
    logic [N-1:0] tgt;
    logic         up;
    // One step of f toward t; any overshoot, modulo wrap or zero step lands exactly on t.
    function automatic logic [N-1:0] step_to(input logic [N-1:0] f, input logic [N-1:0] t,
                                             input logic [N-1:0] s, input logic u);
        logic [N:0] r;
        r = u ? {1'b0, f} + {1'b0, s} : {1'b0, f} - {1'b0, s};
        step_to = (s == '0 || r[N] || (u ? r[N-1:0] > t : r[N-1:0] < t)) ? t : r[N-1:0];
    endfunction
`ifdef DDS_SWEEP_PINGPONG_EN
    logic fwd_q, fwd_d;
    assign tgt = fwd_q ? stop_sh_q : start_sh_q;
    assign up  = fwd_q ? up_sh_q : ~up_sh_q;
`else
    assign tgt = stop_sh_q;
    assign up  = up_sh_q;
`endif
    assign cfg_acc = cfg_valid_i && state_q == IDLE;
    always_comb begin
        state_d = state_q;
        ftw_d   = ftw_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
        fwd_d   = fwd_q;
`endif
        if (abort_i) begin
            state_d = IDLE;
            ftw_d   = '0;
        end else if (start_i && state_q != SWEEP) begin
            state_d = SWEEP;
            ftw_d   = start_sh_q;
            cnt_d   = dwell_sh_q;
`ifdef DDS_SWEEP_PINGPONG_EN
            fwd_d   = 1'b1;
`endif
        end else if (state_q == SWEEP) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - D'(1);
            end else if (ftw_q != tgt) begin
                ftw_d = step_to(ftw_q, tgt, step_sh_q, up);
                cnt_d = dwell_sh_q;
            end else begin
                done_d = 1'b1;
`ifdef DDS_SWEEP_PINGPONG_EN
                fwd_d  = ~fwd_q;
                ftw_d  = step_to(ftw_q, fwd_q ? start_sh_q : stop_sh_q, step_sh_q, ~up);
                cnt_d  = dwell_sh_q;
`else
                state_d = HOLD;
`endif
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ftw_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ftw_q   <= ftw_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
`ifdef DDS_SWEEP_PINGPONG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fwd_q <= 1'b1;
        else        fwd_q <= fwd_d;
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sh_q <= '0;
            stop_sh_q  <= '0;
            step_sh_q  <= '0;
            dwell_sh_q <= '0;
            up_sh_q    <= 1'b0;
        end else if (cfg_acc) begin
            start_sh_q <= cfg_start_i;
            stop_sh_q  <= cfg_stop_i;
            step_sh_q  <= cfg_step_i;
            dwell_sh_q <= cfg_dwell_i;
            up_sh_q    <= cfg_stop_i >= cfg_start_i;
        end
    end
    dds_phase_acc #(.N(N)) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .ftw_i   (ftw_q),
        .phase_o (phase_o),
        .wrap_o  (wrap_o)
    );
    assign cfg_ready_o = state_q == IDLE;
    assign busy_o      = state_q == SWEEP;
    assign done_o      = done_q;
    assign ftw_o       = ftw_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed checks of dds_sweep_ctrl; ping-pong section used when DDS_SWEEP_PINGPONG_EN is defined.
module tb_dds_sweep_ctrl;
    localparam int N = 14;
    localparam int D = 8;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] cfg_start = '0;
    logic [N-1:0] cfg_stop = '0;
    logic [N-1:0] cfg_step = '0;
    logic [D-1:0] cfg_dwell = '0;
    logic         cfg_ready, busy, done, wrap;
    logic [N-1:0] ftw, phase;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    dds_sweep_ctrl #(.N(N), .D(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_start_i (cfg_start),
        .cfg_stop_i  (cfg_stop),
        .cfg_step_i  (cfg_step),
        .cfg_dwell_i (cfg_dwell),
        .start_i     (start),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .ftw_o       (ftw),
        .phase_o     (phase),
        .wrap_o      (wrap)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic cfg(input int s, input int e, input int st, input int dw);
        cfg_start = N'(s);
        cfg_stop  = N'(e);
        cfg_step  = N'(st);
        cfg_dwell = D'(dw);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic chk_all_clear(input string tag);
        chk({tag, "_ready"}, 32'(cfg_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ftw"}, 32'(ftw), 0);
        chk({tag, "_phase"}, 32'(phase), 0);
        chk({tag, "_wrap"}, 32'(wrap), 0);
    endtask
    initial begin
        int n;
        int exp_ftw[8];
        int exp_ph[8];
        int exp_dn[8];
        repeat (2) @(posedge clk);
        #1;
        chk_all_clear("reset");
        rst_n = 1'b1;
`ifdef DDS_SWEEP_PINGPONG_EN
        cfg(0, 2, 1, 0);
        chk("pp_idle_ftw", 32'(ftw), 0);
        exp_ftw = '{0, 1, 2, 1, 0, 1, 2, 1};
        exp_dn  = '{0, 0, 0, 1, 0, 1, 0, 1};
        go();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_ftw%0d", i), 32'(ftw), exp_ftw[i]);
            chk($sformatf("pp_done%0d", i), 32'(done), exp_dn[i]);
            chk($sformatf("pp_busy%0d", i), 32'(busy), 1);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("pp_abort_ready", 32'(cfg_ready), 1);
        chk("pp_abort_ftw", 32'(ftw), 0);
`else
        cfg(100, 400, 100, 1);
        chk("idle_ftw", 32'(ftw), 0);
        exp_ftw = '{100, 100, 200, 200, 300, 300, 400, 400};
        exp_ph  = '{0, 100, 200, 400, 600, 900, 1200, 1600};
        go();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("up_ftw%0d", i), 32'(ftw), exp_ftw[i]);
            chk($sformatf("up_phase%0d", i), 32'(phase), exp_ph[i]);
            chk($sformatf("up_busy%0d", i), 32'(busy), 1);
            chk($sformatf("up_done%0d", i), 32'(done), 0);
            tick();
        end
        chk("up_done", 32'(done), 1);
        chk("up_done_busy", 32'(busy), 0);
        chk("up_done_ftw", 32'(ftw), 400);
        chk("up_done_phase", 32'(phase), 2000);
        tick();
        chk("hold_done", 32'(done), 0);
        chk("hold_ftw", 32'(ftw), 400);
        chk("hold_phase", 32'(phase), 2400);
        chk("hold_ready", 32'(cfg_ready), 0);
        go();
        chk("restart_ftw", 32'(ftw), 100);
        chk("restart_busy", 32'(busy), 1);
        tick();
        #2 rst_n = 1'b0;
        #1 chk_all_clear("midrst");
        #2 rst_n = 1'b1;
        cfg(500, 120, 200, 0);
        go();
        chk("ab_pre_ftw", 32'(ftw), 500);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("ab_ready", 32'(cfg_ready), 1);
        chk("ab_busy", 32'(busy), 0);
        chk("ab_ftw", 32'(ftw), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_phase", 32'(phase), 500);
        tick();
        tick();
        chk("ab_frozen_phase", 32'(phase), 500);
        chk("ab_no_done", 32'(done), 0);
        go();
        chk("dn_ftw0", 32'(ftw), 500);
        tick();
        chk("dn_ftw1", 32'(ftw), 300);
        chk("dn_done1", 32'(done), 0);
        tick();
        chk("dn_ftw2_clamp", 32'(ftw), 120);
        chk("dn_busy2", 32'(busy), 1);
        tick();
        chk("dn_done", 32'(done), 1);
        chk("dn_busy", 32'(busy), 0);
        chk("dn_ftw_hold", 32'(ftw), 120);
        chk("dn_phase", 32'(phase), 1420);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("hold_abort_ready", 32'(cfg_ready), 1);
        cfg(4096, 4096, 0, 0);
        go();
        chk("eq_ftw", 32'(ftw), 4096);
        chk("eq_busy", 32'(busy), 1);
        tick();
        chk("eq_done", 32'(done), 1);
        chk("eq_busy_off", 32'(busy), 0);
        for (int w = 0; w < 3; w++) begin
            n = 0;
            for (int i = 0; i < 4; i++) begin
                n += int'(wrap);
                tick();
            end
            chk($sformatf("wrap_win%0d", w), 32'(n), 1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cfg(10, 50, 0, 0);
        go();
        chk("z_ftw0", 32'(ftw), 10);
        tick();
        chk("z_ftw1", 32'(ftw), 50);
        tick();
        chk("z_done", 32'(done), 1);
        chk("z_ftw_hold", 32'(ftw), 50);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
